// File: rtl/fetch_realign_buffer.sv
// Realigns word-aligned fetch responses into whole instructions (16- or 32-bit)
// for the decode stage, tracking the PC and handling halfword-aligned redirects.
module fetch_realign_buffer #(
    parameter int                ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] BOOT_PC         = '0,
    parameter int                MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              rsp_valid_i,
    input  logic [31:0]       rsp_data_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              is_compressed_o
);

    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    logic [15:0]       queue [4];
    logic [1:0]        rd_ptr;
    logic [2:0]        hw_count;
    logic [1:0]        outstanding;
    logic [1:0]        drop_count;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] head_pc;
    logic              skip_hw;

    logic [15:0] head;
    logic [15:0] next_hw;
    logic        head_compressed;
    logic        avail;
    logic [2:0]  in_flight;
    logic [3:0]  need;
    logic        issue;
    logic        accept;
    logic        drop;
    logic        pop;
    logic [2:0]  push_n;
    logic [2:0]  pop_n;
    logic [1:0]  wr_ptr;

    assign head            = queue[rd_ptr];
    assign next_hw         = queue[rd_ptr + 2'd1];
    assign head_compressed = (head[1:0] != 2'b11);
    assign avail           = head_compressed ? (hw_count >= 3'd1) : (hw_count >= 3'd2);

    assign instr_valid_o   = avail;
    assign instr_o         = !avail ? 32'h0 :
                             head_compressed ? {16'h0, head} : {next_hw, head};
    assign pc_o            = avail ? head_pc : '0;
    assign is_compressed_o = avail & head_compressed;

    // Responses still owed by memory (live or to be discarded) share one credit pool;
    // queue space for a live request is reserved at issue so responses never stall.
    assign in_flight   = {1'b0, outstanding} + {1'b0, drop_count};
    assign need        = 4'(hw_count) + 4'({outstanding, 1'b0}) + 4'd2;
    assign req_valid_o = !reset && !flush_i && (in_flight < MAX_OUT) && (need <= 4'd4);
    assign req_addr_o  = fetch_addr;

    assign issue  = req_valid_o && req_ready_i;
    assign accept = rsp_valid_i && (drop_count == 2'd0);
    assign drop   = rsp_valid_i && (drop_count != 2'd0);
    assign pop    = avail && instr_ready_i;
    assign push_n = !accept ? 3'd0 : (skip_hw ? 3'd1 : 3'd2);
    assign pop_n  = !pop ? 3'd0 : (head_compressed ? 3'd1 : 3'd2);
    assign wr_ptr = rd_ptr + hw_count[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) queue[i] <= 16'h0;
            rd_ptr      <= 2'd0;
            hw_count    <= 3'd0;
            outstanding <= 2'd0;
            drop_count  <= 2'd0;
            fetch_addr  <= BOOT_PC & ~ADDR_W'(3);
            head_pc     <= BOOT_PC & ~ADDR_W'(1);
            skip_hw     <= BOOT_PC[1];
        end else if (flush_i) begin
            // Everything still owed after this cycle belongs to the old path.
            rd_ptr      <= 2'd0;
            hw_count    <= 3'd0;
            outstanding <= 2'd0;
            drop_count  <= 2'(in_flight - 3'(rsp_valid_i));
            fetch_addr  <= flush_pc_i & ~ADDR_W'(3);
            head_pc     <= flush_pc_i & ~ADDR_W'(1);
            skip_hw     <= flush_pc_i[1];
        end else begin
            if (issue) fetch_addr <= fetch_addr + ADDR_W'(4);
            outstanding <= outstanding + 2'(issue) - 2'(accept);
            if (drop) drop_count <= drop_count - 2'd1;
            if (accept) begin
                skip_hw <= 1'b0;
                if (skip_hw) begin
                    queue[wr_ptr] <= rsp_data_i[31:16];
                end else begin
                    queue[wr_ptr]         <= rsp_data_i[15:0];
                    queue[wr_ptr + 2'd1]  <= rsp_data_i[31:16];
                end
            end
            hw_count <= hw_count + push_n - pop_n;
            if (pop) begin
                rd_ptr  <= rd_ptr + pop_n[1:0];
                head_pc <= head_pc + ADDR_W'({pop_n, 1'b0});
            end
        end
    end

endmodule
